// File: rtl/voq_pkg.sv
// Shared types and width/index helpers for the VOQ ingress dispatcher.
package voq_pkg;

  // Packet-level dispatcher state: between packets, forwarding one, or discarding one.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Destination select width; never collapses to a zero-width port.
  function automatic int sel_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Priority class width, at least one bit.
  function automatic int pri_w(input int num_class);
    return (num_class > 1) ? $clog2(num_class) : 1;
  endfunction

  // Total number of VOQ write ports.
  function automatic int q_num(input int num_ports, input int num_class);
    return num_ports * num_class;
  endfunction

  // Width of an index into the VOQ array, at least one bit.
  function automatic int qidx_w(input int q);
    return (q > 1) ? $clog2(q) : 1;
  endfunction

  // Flat queue index: queues of one destination port are contiguous.
  function automatic int qidx(input int dest, input int prio, input int num_class);
    return dest * num_class + prio;
  endfunction

endpackage

// File: rtl/voq_sat_counter.sv
// Saturating up-counter used for the drop and framing-error statistics.
module voq_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step by one unless already pinned at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/voq_ingress_dispatcher.sv
// Packet-aware ingress dispatcher: steers each word-serial packet, as an atomic
// unit, to one VOQ write port selected by destination and priority at SOP.
module voq_ingress_dispatcher
  import voq_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int NUM_CLASS = 2,
  parameter  int DATA_W    = 8,
  parameter  int DROP_MODE = 0,
  parameter  int CNT_W     = 16,
  localparam int SEL_W     = sel_w(NUM_PORTS),
  localparam int PRI_W     = pri_w(NUM_CLASS),
  localparam int Q         = q_num(NUM_PORTS, NUM_CLASS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_dest,
  input  logic [PRI_W-1:0]  in_prio,
  input  logic [Q-1:0]      voq_full,
  output logic [Q-1:0]      out_wr_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int QI_W = qidx_w(Q);

  state_e            state_q, state_d;
  logic [QI_W-1:0]   q_q, q_d;
  logic [Q-1:0]      wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  logic              sop_bad;
  logic              sop_full;
  logic [QI_W-1:0]   sop_qi;
  logic              ready_c;
  logic              wr;
  logic [QI_W-1:0]   wr_idx;
  logic              drop_inc;
  logic              err_inc;

  // Queue addressed by the word on the input if it is taken as a SOP. An
  // out-of-range class is treated like a bad destination so the index never
  // leaves 0..Q-1.
  always_comb begin
    sop_bad  = (int'(in_dest) >= NUM_PORTS) || (int'(in_prio) >= NUM_CLASS);
    sop_qi   = QI_W'(qidx(int'(in_dest), int'(in_prio), NUM_CLASS));
    sop_full = !sop_bad && voq_full[sop_qi];
  end

  // Packet FSM: a SOP is always evaluated afresh (closing any open packet with a
  // framing error); other words follow the packet that is currently open.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    ready_c  = 1'b1;
    wr       = 1'b0;
    wr_idx   = q_q;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    if (in_valid && in_sop) begin
      err_inc = (state_q != ST_IDLE);
      if (sop_bad) begin
        drop_inc = 1'b1;
        state_d  = in_eop ? ST_IDLE : ST_DROP;
      end else if (!sop_full) begin
        wr      = 1'b1;
        wr_idx  = sop_qi;
        q_d     = sop_qi;
        state_d = in_eop ? ST_IDLE : ST_FWD;
      end else if (DROP_MODE == 0) begin
        // Hold the SOP; falling back to IDLE keeps the error above one-shot.
        ready_c = 1'b0;
        state_d = ST_IDLE;
      end else begin
        drop_inc = 1'b1;
        state_d  = in_eop ? ST_IDLE : ST_DROP;
      end
    end else begin
      case (state_q)
        ST_FWD: begin
          ready_c = !voq_full[q_q];
          if (in_valid && ready_c) begin
            wr = 1'b1;
            if (in_eop) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (in_valid && in_eop) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          err_inc = in_valid;
        end
      endcase
    end
  end

  // Output stage inputs: one-hot strobe and the routed word, framing cleared when idle.
  always_comb begin
    wr_en_d = '0;
    data_d  = data_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    if (wr) begin
      wr_en_d[wr_idx] = 1'b1;
      data_d          = in_data;
      sop_d           = in_sop;
      eop_d           = in_eop;
    end
  end

  // FSM, latched queue and the single output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      wr_en_q <= '0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  voq_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

  voq_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  assign in_ready  = ready_c && !rst;
  assign out_wr_en = wr_en_q;
  assign out_data  = data_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;

endmodule

// File: tb/tb_voq_ingress_dispatcher.sv
// Bench for voq_ingress_dispatcher: hold-mode (16-bit counters) and drop-mode
// (2-bit counters) instances checked every cycle against a packet-level model.
module tb_voq_ingress_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid [2];
  logic       in_ready [2];
  logic       in_sop   [2];
  logic       in_eop   [2];
  logic [7:0] in_data  [2];
  logic [1:0] in_dest  [2];
  logic       in_prio  [2];
  logic [7:0] voq_full [2];
  logic [7:0] out_wr_en[2];
  logic [7:0] out_data [2];
  logic       out_sop  [2];
  logic       out_eop  [2];
  logic [15:0] drop_cnt0, err_cnt0;
  logic [1:0]  drop_cnt1, err_cnt1;

  int tests = 0;
  int fails = 0;

  // Model: open_q = -1 between packets, -2 while discarding, else the queue in use.
  int         open_q [2];
  int         m_drop [2];
  int         m_err  [2];
  int         cmax   [2] = '{65535, 3};
  logic [7:0] e_wr   [2];
  logic [7:0] e_data [2];
  logic       e_sop  [2];
  logic       e_eop  [2];
  int         hits   [2][8];
  int         rel_cnt[2];
  bit         acc    [2];
  int         waited;

  voq_ingress_dispatcher #(.NUM_PORTS(4), .NUM_CLASS(2), .DATA_W(8), .DROP_MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sop(in_sop[0]),
    .in_eop(in_eop[0]), .in_data(in_data[0]), .in_dest(in_dest[0]), .in_prio(in_prio[0]),
    .voq_full(voq_full[0]), .out_wr_en(out_wr_en[0]), .out_data(out_data[0]), .out_sop(out_sop[0]),
    .out_eop(out_eop[0]), .drop_cnt(drop_cnt0), .err_cnt(err_cnt0));

  voq_ingress_dispatcher #(.NUM_PORTS(4), .NUM_CLASS(2), .DATA_W(8), .DROP_MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sop(in_sop[1]),
    .in_eop(in_eop[1]), .in_data(in_data[1]), .in_dest(in_dest[1]), .in_prio(in_prio[1]),
    .voq_full(voq_full[1]), .out_wr_en(out_wr_en[1]), .out_data(out_data[1]), .out_sop(out_sop[1]),
    .out_eop(out_eop[1]), .drop_cnt(drop_cnt1), .err_cnt(err_cnt1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dcnt(input int d);
    return (d == 0) ? drop_cnt0 : {14'd0, drop_cnt1};
  endfunction

  function automatic logic [15:0] ecnt(input int d);
    return (d == 0) ? err_cnt0 : {14'd0, err_cnt1};
  endfunction

  function automatic int hsum(input int d);
    int s = 0;
    for (int i = 0; i < 8; i++) s += hits[d][i];
    return s;
  endfunction

  task automatic clear_hits();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) hits[d][i] = 0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      open_q[d] = -1; m_drop[d] = 0; m_err[d] = 0;
      e_wr[d] = 8'h00; e_data[d] = 8'h00; e_sop[d] = 1'b0; e_eop[d] = 1'b0;
    end
  endtask

  // Packet-level rules for the word on the inputs of instance d.
  function automatic void predict(input int d, output bit rdy, output bit wr, output int tq,
                                  output int nopen, output bit dinc, output bit einc);
    int q;
    rdy = 1'b1; wr = 1'b0; tq = open_q[d]; nopen = open_q[d]; dinc = 1'b0; einc = 1'b0;
    if (!in_valid[d]) return;
    q = int'(in_dest[d]) * 2 + int'(in_prio[d]);
    if (in_sop[d]) begin
      einc = (open_q[d] != -1);
      if (voq_full[d][q]) begin
        if (d == 0) begin rdy = 1'b0; nopen = -1; end
        else begin dinc = 1'b1; nopen = in_eop[d] ? -1 : -2; end
      end else begin
        wr = 1'b1; tq = q; nopen = in_eop[d] ? -1 : q;
      end
    end else if (open_q[d] == -1) begin
      einc = 1'b1;
    end else if (open_q[d] >= 0) begin
      rdy = !voq_full[d][open_q[d]];
      wr  = rdy;
      if (rdy && in_eop[d]) nopen = -1;
    end else if (in_eop[d]) begin
      nopen = -1;
    end
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic tick();
    bit rdy [2]; bit wr [2]; int tq [2]; int nopen [2]; bit dinc [2]; bit einc [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      predict(d, rdy[d], wr[d], tq[d], nopen[d], dinc[d], einc[d]);
      if (in_valid[d]) chk($sformatf("in_ready[%0d]", d), 64'(in_ready[d]), 64'(rdy[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d]    = in_valid[d] && rdy[d];
      open_q[d] = nopen[d];
      if (dinc[d] && m_drop[d] < cmax[d]) m_drop[d]++;
      if (einc[d] && m_err[d] < cmax[d]) m_err[d]++;
      if (wr[d]) begin
        e_wr[d] = 8'(1) << tq[d]; e_data[d] = in_data[d]; e_sop[d] = in_sop[d]; e_eop[d] = in_eop[d];
      end else begin
        e_wr[d] = 8'h00; e_sop[d] = 1'b0; e_eop[d] = 1'b0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("outputs[%0d]", d),
          {14'd0, out_wr_en[d], out_data[d], out_sop[d], out_eop[d], dcnt(d), ecnt(d)},
          {14'd0, e_wr[d], e_data[d], e_sop[d], e_eop[d], 16'(m_drop[d]), 16'(m_err[d])});
      for (int i = 0; i < 8; i++) if (out_wr_en[d][i] === 1'b1) hits[d][i]++;
      if (rel_cnt[d] > 0) begin
        rel_cnt[d]--;
        if (rel_cnt[d] == 0) voq_full[d] = 8'h00;
      end
    end
  endtask

  task automatic send_word(input int d, input bit sop, input bit eop, input logic [7:0] data,
                           input logic [1:0] dest, input bit prio);
    in_valid[d] = 1'b1; in_sop[d] = sop; in_eop[d] = eop;
    in_data[d] = data; in_dest[d] = dest; in_prio[d] = prio;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!acc[d] && waited < 50);
    chk("word_accepted", 64'(acc[d]), 64'd1);
    in_valid[d] = 1'b0;
  endtask

  task automatic send_pkt(input int d, input logic [1:0] dest, input bit prio, input int len,
                          input logic [7:0] base);
    for (int i = 0; i < len; i++)
      send_word(d, i == 0, i == len - 1, base + 8'(i), dest, prio);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1; in_sop[d] = 1'b1;
      #0;
      chk($sformatf("rst_in_ready[%0d]", d), 64'(in_ready[d]), 64'd0);
      chk($sformatf("rst_state[%0d]", d),
          {14'd0, out_wr_en[d], out_data[d], out_sop[d], out_eop[d], dcnt(d), ecnt(d)}, 64'd0);
      in_valid[d] = 1'b0; in_sop[d] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_sop[d] = 1'b0; in_eop[d] = 1'b0; in_data[d] = 8'h00;
      in_dest[d] = 2'd0; in_prio[d] = 1'b0; voq_full[d] = 8'h00; rel_cnt[d] = 0;
    end
    clear_hits();
    @(negedge clk);
    do_reset();

    // 3-word packet to dest 2 / class 1 lands on queue 5 only.
    send_pkt(0, 2'd2, 1'b1, 3, 8'hA0);
    chk("pkt_q5_writes", 64'(hits[0][5]), 64'd3);
    chk("pkt_total_writes", 64'(hsum(0)), 64'd3);

    // Hold mode: SOP waits while queue 5 is full, taken on the edge after release.
    clear_hits();
    voq_full[0] = 8'h20; rel_cnt[0] = 3;
    send_word(0, 1'b1, 1'b0, 8'h11, 2'd2, 1'b1);
    chk("hold_sop_cycles", 64'(waited), 64'd4);
    send_word(0, 1'b0, 1'b1, 8'h12, 2'd0, 1'b0);
    chk("hold_q5_writes", 64'(hits[0][5]), 64'd2);

    // Drop mode: same packet is consumed without any write.
    clear_hits();
    voq_full[1] = 8'h20;
    send_pkt(1, 2'd2, 1'b1, 2, 8'h30);
    voq_full[1] = 8'h00;
    chk("dropmode_drop_cnt", 64'(drop_cnt1), 64'd1);
    chk("dropmode_no_writes", 64'(hsum(1)), 64'd0);

    // Full pulse mid-packet on queue 2 stalls without losing or repeating words.
    clear_hits();
    send_word(0, 1'b1, 1'b0, 8'h40, 2'd1, 1'b0);
    send_word(0, 1'b0, 1'b0, 8'h41, 2'd3, 1'b1);
    voq_full[0] = 8'h04; rel_cnt[0] = 2;
    send_word(0, 1'b0, 1'b0, 8'h42, 2'd3, 1'b1);
    chk("midpkt_stall_cycles", 64'(waited), 64'd3);
    send_word(0, 1'b0, 1'b1, 8'h43, 2'd3, 1'b1);
    chk("midpkt_q2_writes", 64'(hits[0][2]), 64'd4);

    // Framing errors: stray word in IDLE, then a SOP that cuts an open packet.
    clear_hits();
    send_word(0, 1'b0, 1'b0, 8'h50, 2'd1, 1'b1);
    send_word(0, 1'b1, 1'b0, 8'h51, 2'd0, 1'b0);
    send_word(0, 1'b1, 1'b1, 8'h52, 2'd3, 1'b0);
    chk("framing_err_cnt", 64'(err_cnt0), 64'd2);
    chk("framing_q0_writes", 64'(hits[0][0]), 64'd1);
    chk("framing_q6_writes", 64'(hits[0][6]), 64'd1);

    // Reset in the middle of a packet, then a clean packet.
    clear_hits();
    send_word(0, 1'b1, 1'b0, 8'h60, 2'd3, 1'b1);
    send_word(0, 1'b0, 1'b0, 8'h61, 2'd3, 1'b1);
    chk("pre_reset_wr_en", 64'(out_wr_en[0]), 64'h80);
    do_reset();
    clear_hits();
    send_pkt(0, 2'd0, 1'b1, 2, 8'h70);
    chk("post_reset_q1_writes", 64'(hits[0][1]), 64'd2);
    chk("post_reset_total", 64'(hsum(0)), 64'd2);

    // Randomized traffic on both instances with full bursts and stray SOP flags.
    for (int n = 0; n < 150; n++) begin
      int d, len;
      logic [1:0] dest;
      bit prio, sop;
      d    = int'($urandom_range(0, 1));
      len  = int'($urandom_range(1, 4));
      dest = 2'($urandom);
      prio = 1'($urandom);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          voq_full[d] = 8'($urandom);
          rel_cnt[d]  = int'($urandom_range(1, 4));
        end
        sop = (i == 0);
        if ($urandom_range(0, 11) == 0) sop = !sop;
        send_word(d, sop, i == len - 1, 8'($urandom), dest, prio);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
